// File: rtl/control_decode_pipe.sv
// ID-stage instruction decoder with load-use hazard detection and an ID/EX
// pipeline register supporting valid, stall and flush.
module control_decode_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int IMM_W  = 17,
    parameter int TGT_W  = 27
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instruction,
    input  logic              id_valid,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic [REG_W-1:0]  read_reg_s1,
    output logic [REG_W-1:0]  read_reg_s2,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic              ex_bne,
    output logic              ex_blt,
    output logic              ex_beq,
    output logic              ex_bex,
    output logic              ex_setx,
    output logic [DATA_W-1:0] ex_branch_N,
    output logic [REG_W-1:0]  ex_s1,
    output logic [REG_W-1:0]  ex_s2
);

    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] OP_SETX = 5'b10101;

    logic [4:0]        w_op;
    logic              w_rd_rt;
    logic              w_bne;
    logic              w_blt;
    logic              w_beq;
    logic              w_bex;
    logic              w_setx;
    logic [DATA_W-1:0] w_branch_N;

    logic              r_valid;
    logic              r_bne;
    logic              r_blt;
    logic              r_beq;
    logic              r_bex;
    logic              r_setx;
    logic [DATA_W-1:0] r_branch_N;
    logic [REG_W-1:0]  r_s1;
    logic [REG_W-1:0]  r_s2;

    assign w_op = instruction[DATA_W-1:DATA_W-5];

    assign w_rd_rt = (w_op == 5'b00010) || (w_op == 5'b00100) ||
                     (w_op == 5'b00110) || (w_op == 5'b00111) ||
                     (w_op == 5'b10000) || (w_op == 5'b10001);

    assign read_reg_s1 = instruction[21:17];
    assign read_reg_s2 = w_rd_rt ? instruction[26:22] : instruction[16:12];

    // Flags are masked by id_valid so an empty ID slot can never fire a branch.
    assign w_bne  = id_valid && (w_op == OP_BNE);
    assign w_blt  = id_valid && (w_op == OP_BLT);
    assign w_beq  = id_valid && (w_op == OP_BEQ);
    assign w_bex  = id_valid && (w_op == OP_BEX);
    assign w_setx = id_valid && (w_op == OP_SETX);

    always_comb begin
        w_branch_N = '0;
        case (w_op)
            OP_BNE, OP_BLT, OP_BEQ:
                w_branch_N = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
            OP_BEX, OP_SETX:
                w_branch_N = {{(DATA_W-TGT_W){instruction[TGT_W-1]}}, instruction[TGT_W-1:0]};
            default:
                w_branch_N = '0;
        endcase
    end

    assign hazard_stall = id_valid && r_valid && ex_is_load && (ex_rd != '0) &&
                          ((ex_rd == read_reg_s1) || (ex_rd == read_reg_s2));

    // Priority: flush beats stall, stall beats hazard bubble, else issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_bne      <= 1'b0;
            r_blt      <= 1'b0;
            r_beq      <= 1'b0;
            r_bex      <= 1'b0;
            r_setx     <= 1'b0;
            r_branch_N <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
        end else if (flush_in || (!stall_in && hazard_stall)) begin
            r_valid    <= 1'b0;
            r_bne      <= 1'b0;
            r_blt      <= 1'b0;
            r_beq      <= 1'b0;
            r_bex      <= 1'b0;
            r_setx     <= 1'b0;
            r_branch_N <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
        end else if (!stall_in) begin
            r_valid    <= id_valid;
            r_bne      <= w_bne;
            r_blt      <= w_blt;
            r_beq      <= w_beq;
            r_bex      <= w_bex;
            r_setx     <= w_setx;
            r_branch_N <= w_branch_N;
            r_s1       <= read_reg_s1;
            r_s2       <= read_reg_s2;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_bne      = r_bne;
    assign ex_blt      = r_blt;
    assign ex_beq      = r_beq;
    assign ex_bex      = r_bex;
    assign ex_setx     = r_setx;
    assign ex_branch_N = r_branch_N;
    assign ex_s1       = r_s1;
    assign ex_s2       = r_s2;

endmodule

// File: tb/tb_control_decode_pipe.sv
// Directed bench for control_decode_pipe: default widths plus a narrow-field
// instance for immediate sign-extension at IMM_W=12, TGT_W=20.
module tb_control_decode_pipe;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic        idValid;
    logic        exIsLoad;
    logic [4:0]  exRd;
    logic        stallIn;
    logic        flushIn;
    logic [4:0]  readRegS1;
    logic [4:0]  readRegS2;
    logic        hazardStall;
    logic        exValid;
    logic        exBne;
    logic        exBlt;
    logic        exBeq;
    logic        exBex;
    logic        exSetx;
    logic [31:0] exBranchN;
    logic [4:0]  exS1;
    logic [4:0]  exS2;

    logic [31:0] nInstruction;
    logic        nIdValid;
    logic [4:0]  nReadRegS1;
    logic [4:0]  nReadRegS2;
    logic        nHazardStall;
    logic        nExValid;
    logic        nExBne;
    logic        nExBlt;
    logic        nExBeq;
    logic        nExBex;
    logic        nExSetx;
    logic [31:0] nExBranchN;
    logic [4:0]  nExS1;
    logic [4:0]  nExS2;

    int compared   = 0;
    int mismatched = 0;

    control_decode_pipe dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .id_valid     (idValid),
        .ex_is_load   (exIsLoad),
        .ex_rd        (exRd),
        .stall_in     (stallIn),
        .flush_in     (flushIn),
        .read_reg_s1  (readRegS1),
        .read_reg_s2  (readRegS2),
        .hazard_stall (hazardStall),
        .ex_valid     (exValid),
        .ex_bne       (exBne),
        .ex_blt       (exBlt),
        .ex_beq       (exBeq),
        .ex_bex       (exBex),
        .ex_setx      (exSetx),
        .ex_branch_N  (exBranchN),
        .ex_s1        (exS1),
        .ex_s2        (exS2)
    );

    control_decode_pipe #(.IMM_W(12), .TGT_W(20)) dutNarrow (
        .clock        (clock),
        .reset        (reset),
        .instruction  (nInstruction),
        .id_valid     (nIdValid),
        .ex_is_load   (1'b0),
        .ex_rd        (5'd0),
        .stall_in     (1'b0),
        .flush_in     (1'b0),
        .read_reg_s1  (nReadRegS1),
        .read_reg_s2  (nReadRegS2),
        .hazard_stall (nHazardStall),
        .ex_valid     (nExValid),
        .ex_bne       (nExBne),
        .ex_blt       (nExBlt),
        .ex_beq       (nExBeq),
        .ex_bex       (nExBex),
        .ex_setx      (nExSetx),
        .ex_branch_N  (nExBranchN),
        .ex_s1        (nExS1),
        .ex_s2        (nExS2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic valid);
        instruction = instr;
        idValid     = valid;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        instruction  = '0;
        idValid      = 1'b0;
        exIsLoad     = 1'b0;
        exRd         = '0;
        stallIn      = 1'b0;
        flushIn      = 1'b0;
        nInstruction = '0;
        nIdValid     = 1'b0;
        #2;
        checkOutput("reset ex_valid", {31'd0, exValid}, 32'd0);
        checkOutput("reset ex_branch_N", exBranchN, 32'd0);
        checkOutput("reset flags", {27'd0, exBne, exBlt, exBeq, exBex, exSetx}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        stepCycle();

        // bne: rd=1, rs=2, 17-bit immediate all ones
        applyStimulus(32'h1045_FFFF, 1'b1);
        checkOutput("bne read_reg_s1", {27'd0, readRegS1}, 32'd2);
        checkOutput("bne read_reg_s2", {27'd0, readRegS2}, 32'd1);
        stepCycle();
        checkOutput("bne ex_bne", {31'd0, exBne}, 32'd1);
        checkOutput("bne ex_valid", {31'd0, exValid}, 32'd1);
        checkOutput("bne ex_branch_N", exBranchN, 32'hFFFF_FFFF);

        // setx with target bit 26 set sign-extends into the top bits
        applyStimulus(32'hAC00_0000, 1'b1);
        stepCycle();
        checkOutput("setx ex_setx", {31'd0, exSetx}, 32'd1);
        checkOutput("setx ex_bne", {31'd0, exBne}, 32'd0);
        checkOutput("setx ex_branch_N", exBranchN, 32'hFC00_0000);

        // add: no flags, zero immediate, s2 from bits 16:12
        applyStimulus(32'h0044_3000, 1'b1);
        checkOutput("add read_reg_s2", {27'd0, readRegS2}, 32'd3);
        stepCycle();
        checkOutput("add ex_branch_N", exBranchN, 32'd0);
        checkOutput("add flags", {27'd0, exBne, exBlt, exBeq, exBex, exSetx}, 32'd0);

        // load-use hazard: lw into EX, then consumer with rs=3
        applyStimulus(32'h4000_0000, 1'b1);
        stepCycle();
        exIsLoad = 1'b1;
        exRd     = 5'd3;
        applyStimulus(32'h0006_0000, 1'b1);
        checkOutput("hazard asserted", {31'd0, hazardStall}, 32'd1);
        stepCycle();
        checkOutput("hazard bubble ex_valid", {31'd0, exValid}, 32'd0);
        checkOutput("hazard cleared", {31'd0, hazardStall}, 32'd0);
        exIsLoad = 1'b0;
        stepCycle();
        checkOutput("hazard reissue ex_valid", {31'd0, exValid}, 32'd1);
        checkOutput("hazard reissue ex_s1", {27'd0, exS1}, 32'd3);
        exIsLoad = 1'b1;
        exRd     = 5'd0;
        applyStimulus(32'h0000_0000, 1'b1);
        checkOutput("hazard rd0 none", {31'd0, hazardStall}, 32'd0);
        exIsLoad = 1'b0;

        // flush beats stall
        flushIn = 1'b1;
        stallIn = 1'b1;
        applyStimulus(32'h8000_0005, 1'b1);
        stepCycle();
        checkOutput("flush ex_valid", {31'd0, exValid}, 32'd0);
        checkOutput("flush ex_beq", {31'd0, exBeq}, 32'd0);
        checkOutput("flush ex_branch_N", exBranchN, 32'd0);
        flushIn = 1'b0;
        stallIn = 1'b0;
        stepCycle();
        checkOutput("beq ex_beq", {31'd0, exBeq}, 32'd1);
        checkOutput("beq ex_branch_N", exBranchN, 32'd5);

        // stall alone holds the register for three cycles
        stallIn = 1'b1;
        applyStimulus(32'h0044_3000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("stall hold ex_beq", {31'd0, exBeq}, 32'd1);
            checkOutput("stall hold ex_branch_N", exBranchN, 32'd5);
            checkOutput("stall hold ex_valid", {31'd0, exValid}, 32'd1);
        end
        stallIn = 1'b0;

        // asynchronous reset between edges
        applyStimulus(32'h1045_FFFF, 1'b1);
        stepCycle();
        checkOutput("pre-reset ex_bne", {31'd0, exBne}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async reset ex_valid", {31'd0, exValid}, 32'd0);
        checkOutput("async reset ex_bne", {31'd0, exBne}, 32'd0);
        checkOutput("async reset ex_branch_N", exBranchN, 32'd0);
        checkOutput("async reset ex_s1", {27'd0, exS1}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // narrow fields: IMM_W=12, TGT_W=20
        nInstruction = 32'h1000_0800;
        nIdValid     = 1'b1;
        stepCycle();
        checkOutput("narrow bne ex_bne", {31'd0, nExBne}, 32'd1);
        checkOutput("narrow bne ex_branch_N", nExBranchN, 32'hFFFF_F800);
        nInstruction = 32'hB007_FFFF;
        stepCycle();
        checkOutput("narrow bex ex_bex", {31'd0, nExBex}, 32'd1);
        checkOutput("narrow bex ex_branch_N", nExBranchN, 32'h0007_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
